// File: rtl/result_tx_ctrl.sv
// Result transmit controller: queues finished results, feeds them byte by
// byte to a UART transmitter with programmable pacing, and mirrors selected results to a display.
module result_tx_ctrl #(
  parameter int RESULT_W         = 32,
  parameter int FIFO_DEPTH       = 4,
  parameter int INTER_BYTE_DELAY = 1000000,
  parameter int LOAD_DELAY       = 100,
  parameter int MSB_FIRST        = 0,
  localparam int NB              = RESULT_W / 8,
  localparam int CW              = $clog2(NB + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                op_done,
  input  logic [RESULT_W-1:0] result_data,
  input  logic [CW-1:0]       byte_count,
  input  logic                disp_req,
  input  logic                tx_busy,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  output logic [RESULT_W-1:0] disp_data,
  output logic                disp_en,
  output logic                fifo_full,
  output logic                overflow,
  output logic                idle
);

  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW    = RESULT_W + CW + 1;
  localparam int TMAX  = (LOAD_DELAY > INTER_BYTE_DELAY) ? LOAD_DELAY : INTER_BYTE_DELAY;
  localparam int TW    = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, WAIT_LOAD, START, WAIT_BUSY, WAIT_DONE, GAP
  } state_t;

  state_t              state_reg, state_next;

  logic [EW-1:0]       fifo_mem [FIFO_DEPTH];
  logic [EW-1:0]       head_reg;
  logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [PW:0]         count_reg, count_next;
  logic                fifo_full_reg, overflow_reg;

  logic [RESULT_W-1:0] shift_reg, shift_next;
  logic [CW-1:0]       remain_reg;
  logic [TW-1:0]       timer_reg;
  logic [7:0]          tx_data_reg;
  logic [RESULT_W-1:0] disp_data_reg;
  logic                disp_en_reg;

  logic                push, pop, fifo_empty;
  logic [CW-1:0]       eff_count;
  logic [RESULT_W-1:0] head_data;
  logic [CW-1:0]       head_count;
  logic                head_disp;
  logic [7:0]          sh_bytes [NB];
  logic [7:0]          cur_byte;

  // Out-of-range counts (0 or > NB) fall back to a full-width transfer.
  assign eff_count = (byte_count >= CW'(1) && byte_count <= CW'(NB)) ? byte_count : CW'(NB);

  assign fifo_empty = (count_reg == '0);
  assign pop        = (state_reg == LOAD);
  // A dequeue in the same cycle frees a slot, so a push while full still lands.
  assign push       = op_done && (!fifo_full_reg || pop);

  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + (PW+1)'(1);
    else if (!push && pop)
      count_next = count_reg - (PW+1)'(1);
  end

  // Queue storage: plain array with registered head read.
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= {result_data, eff_count, disp_req};
    head_reg <= fifo_mem[rd_ptr_reg];
  end

  assign head_data  = head_reg[EW-1 -: RESULT_W];
  assign head_count = head_reg[CW:1];
  assign head_disp  = head_reg[0];

  for (genvar gi = 0; gi < NB; gi++) begin : g_bytes
    assign sh_bytes[gi] = shift_reg[gi*8 +: 8];
  end

  assign cur_byte   = (MSB_FIRST != 0) ? sh_bytes[NB-1] : sh_bytes[0];
  assign shift_next = (MSB_FIRST != 0) ? (shift_reg << 8) : (shift_reg >> 8);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (!fifo_empty) state_next = LOAD;
      LOAD:      state_next = WAIT_LOAD;
      WAIT_LOAD: if (timer_reg == '0) state_next = START;
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_next = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) state_next = (remain_reg <= CW'(1)) ? IDLE : GAP;
      GAP:       if (timer_reg == '0) state_next = START;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      fifo_full_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      shift_reg     <= '0;
      remain_reg    <= '0;
      timer_reg     <= '0;
      tx_data_reg   <= '0;
      disp_data_reg <= '0;
      disp_en_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      fifo_full_reg <= (count_next == (PW+1)'(FIFO_DEPTH));
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (op_done && !push)
        overflow_reg <= 1'b1;

      case (state_reg)
        LOAD: begin
          shift_reg   <= head_data;
          remain_reg  <= head_count;
          disp_en_reg <= head_disp;
          if (head_disp)
            disp_data_reg <= head_data;
          timer_reg   <= TW'(LOAD_DELAY - 1);
        end
        WAIT_LOAD, GAP: begin
          if (timer_reg != '0)
            timer_reg <= timer_reg - TW'(1);
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            shift_reg  <= shift_next;
            remain_reg <= remain_reg - CW'(1);
            timer_reg  <= TW'(INTER_BYTE_DELAY - 1);
          end
        end
        default: ;
      endcase

      // Latch the byte on entry to START so it stays put until the next START.
      if (state_next == START && state_reg != START)
        tx_data_reg <= cur_byte;
    end
  end

  assign tx_start  = (state_reg == START);
  assign tx_data   = tx_data_reg;
  assign disp_data = disp_data_reg;
  assign disp_en   = disp_en_reg;
  assign fifo_full = fifo_full_reg;
  assign overflow  = overflow_reg;
  assign idle      = (state_reg == IDLE) && fifo_empty;

endmodule

// File: tb/tb_result_tx_ctrl.sv
// Scoreboard bench for result_tx_ctrl: an LSB-first instance and an MSB-first
// instance, each driven by a simple UART busy model.
module tb_result_tx_ctrl;

  localparam int W  = 32;
  localparam int CW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          op_done, disp_req, op_done_m, disp_req_m;
  logic [W-1:0]  result_data, result_data_m;
  logic [CW-1:0] byte_count, byte_count_m;
  logic          tx_busy, tx_busy_m;
  logic          tx_start, tx_start_m;
  logic [7:0]    tx_data, tx_data_m;
  logic [W-1:0]  disp_data, disp_data_m;
  logic          disp_en, disp_en_m, fifo_full, fifo_full_m;
  logic          overflow, overflow_m, idle, idle_m;

  result_tx_ctrl #(
    .RESULT_W(W), .FIFO_DEPTH(4), .INTER_BYTE_DELAY(10), .LOAD_DELAY(4), .MSB_FIRST(0)
  ) dut (
    .clk(clk), .reset(reset_n), .op_done(op_done), .result_data(result_data),
    .byte_count(byte_count), .disp_req(disp_req), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .disp_data(disp_data), .disp_en(disp_en),
    .fifo_full(fifo_full), .overflow(overflow), .idle(idle)
  );

  result_tx_ctrl #(
    .RESULT_W(W), .FIFO_DEPTH(4), .INTER_BYTE_DELAY(10), .LOAD_DELAY(4), .MSB_FIRST(1)
  ) dut_m (
    .clk(clk), .reset(reset_n), .op_done(op_done_m), .result_data(result_data_m),
    .byte_count(byte_count_m), .disp_req(disp_req_m), .tx_busy(tx_busy_m),
    .tx_start(tx_start_m), .tx_data(tx_data_m), .disp_data(disp_data_m), .disp_en(disp_en_m),
    .fifo_full(fifo_full_m), .overflow(overflow_m), .idle(idle_m)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit uart_en  = 1'b1;
  int busy_cnt, busy_cnt_m;
  logic busy_prev = 1'b0;

  logic [7:0] exp_q[$], act_q[$], expm_q[$], actm_q[$];
  int         act_t[$], fall_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // UART model: busy for 20 cycles after each sampled start pulse.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_cnt   <= 0;
      busy_cnt_m <= 0;
    end else begin
      if (tx_start && uart_en) busy_cnt <= 20;
      else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
      if (tx_start_m)            busy_cnt_m <= 20;
      else if (busy_cnt_m != 0)  busy_cnt_m <= busy_cnt_m - 1;
    end
  end
  assign tx_busy   = (busy_cnt != 0);
  assign tx_busy_m = (busy_cnt_m != 0);

  // Monitor: capture every start pulse, and the first edge that samples tx_busy low.
  always @(negedge clk) begin
    if (tx_start) begin
      act_q.push_back(tx_data);
      act_t.push_back(cyc);
    end
    if (tx_start_m)
      actm_q.push_back(tx_data_m);
    if (busy_prev && !tx_busy)
      fall_q.push_back(cyc + 1);
    busy_prev <= tx_busy;
  end

  task automatic push_op(input bit m, input logic [W-1:0] d, input logic [CW-1:0] c,
                         input logic dr);
    if (m) begin
      op_done_m = 1'b1; result_data_m = d; byte_count_m = c; disp_req_m = dr;
    end else begin
      op_done = 1'b1; result_data = d; byte_count = c; disp_req = dr;
    end
    @(negedge clk);
    op_done   = 1'b0;
    op_done_m = 1'b0;
  endtask

  task automatic clear_queues();
    exp_q.delete(); act_q.delete(); act_t.delete(); fall_q.delete();
    expm_q.delete(); actm_q.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++; if (tx_start !== 1'b0) $display("FAIL rst_tx_start: got %b want 0", tx_start); else n_pass++;
    n_checks++; if (tx_data !== 8'h00) $display("FAIL rst_tx_data: got %h want 00", tx_data); else n_pass++;
    n_checks++; if (disp_data !== 32'h0) $display("FAIL rst_disp_data: got %h want 0", disp_data); else n_pass++;
    n_checks++; if (disp_en !== 1'b0) $display("FAIL rst_disp_en: got %b want 0", disp_en); else n_pass++;
    n_checks++; if (fifo_full !== 1'b0) $display("FAIL rst_fifo_full: got %b want 0", fifo_full); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rst_overflow: got %b want 0", overflow); else n_pass++;
    n_checks++; if (idle !== 1'b1) $display("FAIL rst_idle: got %b want 1", idle); else n_pass++;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (idle !== 1'b1 || tx_start !== 1'b0)
      $display("FAIL post_rst_idle: got idle=%b start=%b want 1/0", idle, tx_start); else n_pass++;
    $display("test_reset done");
  endtask

  task automatic test_single();
    int t0;
    logic [7:0] a, e;
    clear_queues();
    t0 = cyc;
    exp_q.push_back(8'h44); exp_q.push_back(8'h33); exp_q.push_back(8'h22); exp_q.push_back(8'h11);
    push_op(1'b0, 32'h11223344, 3'd4, 1'b0);
    for (int i = 0; i < 1000 && act_q.size() < 4; i++) @(negedge clk);
    n_checks++; if (act_q.size() != 4) $display("FAIL single_count: got %0d want 4", act_q.size()); else n_pass++;
    n_checks++; if (act_t.size() < 1 || act_t[0] - t0 != 7)
      $display("FAIL single_latency: got %0d want 7", act_t.size() ? act_t[0] - t0 : -1); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (i + 1 >= act_t.size() || i >= fall_q.size() || act_t[i+1] - fall_q[i] != 10)
        $display("FAIL single_gap%0d: got %0d want 10", i,
                 (i + 1 < act_t.size() && i < fall_q.size()) ? act_t[i+1] - fall_q[i] : -1);
      else n_pass++;
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 8'hxx;
      n_checks++; if (a !== e) $display("FAIL single_byte%0d: got %h want %h", i, a, e); else n_pass++;
      $display("single byte %0d: %h", i, a);
    end
    for (int i = 0; i < 200 && !(idle && !tx_busy); i++) @(negedge clk);
    n_checks++; if (idle !== 1'b1) $display("FAIL single_idle: got %b want 1", idle); else n_pass++;
  endtask

  task automatic test_msb();
    logic [7:0] a, e;
    clear_queues();
    expm_q.push_back(8'hA1); expm_q.push_back(8'hB2);
    for (int k = 0; k < 2; k++) begin
      expm_q.push_back(8'hA1); expm_q.push_back(8'hB2);
      expm_q.push_back(8'hC3); expm_q.push_back(8'hD4);
    end
    push_op(1'b1, 32'hA1B2C3D4, 3'd2, 1'b0);
    push_op(1'b1, 32'hA1B2C3D4, 3'd0, 1'b0);
    push_op(1'b1, 32'hA1B2C3D4, 3'd7, 1'b0);
    for (int i = 0; i < 3000 && actm_q.size() < 10; i++) @(negedge clk);
    repeat (100) @(negedge clk);
    n_checks++; if (actm_q.size() != 10) $display("FAIL msb_count: got %0d want 10", actm_q.size()); else n_pass++;
    for (int i = 0; expm_q.size() > 0; i++) begin
      e = expm_q.pop_front();
      a = (actm_q.size() > 0) ? actm_q.pop_front() : 8'hxx;
      n_checks++; if (a !== e) $display("FAIL msb_byte%0d: got %h want %h", i, a, e); else n_pass++;
      $display("msb byte %0d: %h", i, a);
    end
    n_checks++; if (idle_m !== 1'b1) $display("FAIL msb_idle: got %b want 1", idle_m); else n_pass++;
  endtask

  task automatic test_display();
    logic [7:0] a, e;
    clear_queues();
    exp_q.push_back(8'h23); exp_q.push_back(8'h00);
    push_op(1'b0, 32'h00000123, 3'd1, 1'b1);
    push_op(1'b0, 32'hFFFF0000, 3'd1, 1'b0);
    n_checks++; if (disp_en !== 1'b0) $display("FAIL disp_pre_load: got %b want 0", disp_en); else n_pass++;
    @(negedge clk);
    n_checks++; if (disp_en !== 1'b1 || disp_data !== 32'h123)
      $display("FAIL disp_after_a: got en=%b data=%h want 1/00000123", disp_en, disp_data); else n_pass++;
    for (int i = 0; i < 1000 && act_q.size() < 2; i++) @(negedge clk);
    n_checks++; if (act_q.size() != 2 || disp_en !== 1'b0 || disp_data !== 32'h123)
      $display("FAIL disp_after_b: got n=%0d en=%b data=%h want 2/0/00000123",
               act_q.size(), disp_en, disp_data); else n_pass++;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 8'hxx;
      n_checks++; if (a !== e) $display("FAIL disp_byte%0d: got %h want %h", i, a, e); else n_pass++;
      $display("display byte %0d: %h", i, a);
    end
    for (int i = 0; i < 200 && !(idle && !tx_busy); i++) @(negedge clk);
  endtask

  task automatic test_overflow();
    logic [7:0] a, e;
    logic b_prev;
    bit found;
    clear_queues();
    exp_q.push_back(8'hAA);
    push_op(1'b0, 32'h000000AA, 3'd1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(8'(k));
      push_op(1'b0, W'(k), 3'd1, 1'b0);
    end
    n_checks++; if (fifo_full !== 1'b1 || overflow !== 1'b0)
      $display("FAIL ovf_full: got full=%b ovf=%b want 1/0", fifo_full, overflow); else n_pass++;
    push_op(1'b0, 32'h00000005, 3'd1, 1'b0);
    n_checks++; if (fifo_full !== 1'b1 || overflow !== 1'b1)
      $display("FAIL ovf_drop: got full=%b ovf=%b want 1/1", fifo_full, overflow); else n_pass++;
    // Time a push to land on the LOAD edge that follows the first transfer.
    found  = 1'b0;
    b_prev = tx_busy;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (b_prev && !tx_busy) found = 1'b1;
      b_prev = tx_busy;
    end
    n_checks++; if (!found) $display("FAIL ovf_fall: got none want busy fall"); else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++; if (fifo_full !== 1'b1) $display("FAIL ovf_full_at_load: got %b want 1", fifo_full); else n_pass++;
    exp_q.push_back(8'h06);
    push_op(1'b0, 32'h00000006, 3'd1, 1'b0);
    n_checks++; if (fifo_full !== 1'b1) $display("FAIL ovf_push_on_load: got %b want 1", fifo_full); else n_pass++;
    for (int i = 0; i < 3000 && act_q.size() < 6; i++) @(negedge clk);
    for (int i = 0; i < 200 && !(idle && !tx_busy); i++) @(negedge clk);
    n_checks++; if (act_q.size() != 6) $display("FAIL ovf_count: got %0d want 6", act_q.size()); else n_pass++;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 8'hxx;
      n_checks++; if (a !== e) $display("FAIL ovf_byte%0d: got %h want %h", i, a, e); else n_pass++;
      $display("overflow byte %0d: %h", i, a);
    end
    n_checks++; if (overflow !== 1'b1 || fifo_full !== 1'b0)
      $display("FAIL ovf_sticky: got ovf=%b full=%b want 1/0", overflow, fifo_full); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic b_prev;
    int n;
    clear_queues();
    push_op(1'b0, 32'h04030201, 3'd4, 1'b1);
    push_op(1'b0, 32'h08070605, 3'd4, 1'b0);
    push_op(1'b0, 32'h0C0B0A09, 3'd4, 1'b0);
    for (int i = 0; i < 1000 && act_q.size() < 2; i++) @(negedge clk);
    b_prev = tx_busy;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (b_prev && !tx_busy) break;
      b_prev = tx_busy;
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++; if (tx_start !== 1'b0 || tx_data !== 8'h00 || disp_data !== 32'h0 || disp_en !== 1'b0)
      $display("FAIL mid_rst_data: got start=%b data=%h disp=%h en=%b want 0/00/0/0",
               tx_start, tx_data, disp_data, disp_en); else n_pass++;
    n_checks++; if (fifo_full !== 1'b0 || overflow !== 1'b0 || idle !== 1'b1)
      $display("FAIL mid_rst_flags: got full=%b ovf=%b idle=%b want 0/0/1",
               fifo_full, overflow, idle); else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (idle !== 1'b1) $display("FAIL mid_rst_idle: got %b want 1", idle); else n_pass++;
    n = act_q.size();
    repeat (1000) @(negedge clk);
    n_checks++; if (act_q.size() != n)
      $display("FAIL mid_rst_quiet: got %0d starts want 0", act_q.size() - n); else n_pass++;
  endtask

  task automatic test_stuck();
    clear_queues();
    uart_en = 1'b0;
    push_op(1'b0, 32'h00005566, 3'd2, 1'b0);
    for (int i = 0; i < 200 && act_q.size() < 1; i++) @(negedge clk);
    n_checks++; if (act_q.size() != 1) $display("FAIL stuck_first: got %0d want 1", act_q.size()); else n_pass++;
    repeat (200) @(negedge clk);
    n_checks++; if (act_q.size() != 1 || idle !== 1'b0 || tx_busy !== 1'b0)
      $display("FAIL stuck_hold: got starts=%0d idle=%b want 1/0", act_q.size(), idle); else n_pass++;
    uart_en = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    op_done = 1'b0; result_data = '0; byte_count = '0; disp_req = 1'b0;
    op_done_m = 1'b0; result_data_m = '0; byte_count_m = '0; disp_req_m = 1'b0;
    test_reset();
    test_single();
    test_msb();
    test_display();
    test_overflow();
    test_reset_mid();
    test_stuck();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_tx_ctrl.md
RESULT_TX_CTRL -- requirements
Module: result_tx_ctrl

Interface
REQ-001 SHALL have parameters:
- RESULT_W, default 32, result width; multiple of 8, at least 8.
- FIFO_DEPTH, default 4, result queue depth; power of 2, at least 2.
- INTER_BYTE_DELAY, default 1000000, idle clk cycles between consecutive bytes; at least 1.
- LOAD_DELAY, default 100, clk cycles from dequeue to first byte; at least 1.
- MSB_FIRST, default 0; 0 sends LSB byte first, 1 sends MSB byte first.
REQ-002 NB = RESULT_W/8; CW = clog2(NB+1).
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
- op_done  in  1  one-cycle pulse; enqueue the result.
- result_data  in  RESULT_W  result sampled with op_done.
- byte_count  in  CW  bytes to send, sampled with op_done.
- disp_req  in  1  result goes to display, sampled with op_done.
- tx_busy  in  1  UART transmitter busy.
- tx_start  out  1  one-cycle UART start pulse.
- tx_data  out  8  byte to UART.
- disp_data  out  RESULT_W  display value.
- disp_en  out  1  display enable.
- fifo_full  out  1  queue full.
- overflow  out  1  sticky drop flag.
- idle  out  1  FSM in IDLE and queue empty.

Function
REQ-004 Queue entries SHALL hold {result_data, effective count, disp_req}; effective count = byte_count if 1..NB, else NB.
REQ-005 op_done while not full SHALL enqueue at that edge.
REQ-006 op_done while full SHALL drop the entry and set overflow; overflow clears only on reset.
- Exception: if a dequeue occurs in the same cycle, the push SHALL succeed.
REQ-007 fifo_full SHALL equal (occupancy == FIFO_DEPTH), registered; pointers wrap modulo FIFO_DEPTH.
REQ-008 FSM states SHALL be IDLE, LOAD, WAIT_LOAD, START, WAIT_BUSY, WAIT_DONE, GAP.
REQ-009 IDLE with queue non-empty -> LOAD; queue empty -> stay in IDLE.
REQ-010 LOAD (1 cycle) SHALL dequeue the head entry into the shift register and remaining-byte counter, then go to WAIT_LOAD.
- In the same cycle, disp_data <= result if disp_req = 1; disp_en <= disp_req.
REQ-011 WAIT_LOAD SHALL last exactly LOAD_DELAY cycles, then go to START.
REQ-012 START (1 cycle) SHALL assert tx_start = 1 with tx_data = current byte, then go to WAIT_BUSY.
- Current byte is byte[0] first if MSB_FIRST = 0; byte[NB-1] first if MSB_FIRST = 1.
REQ-013 tx_data SHALL stay stable from START until the next START.
REQ-014 WAIT_BUSY SHALL wait for tx_busy = 1, then go to WAIT_DONE.
REQ-015 WAIT_DONE SHALL wait for tx_busy = 0, then decrement the remaining count and shift to the next byte in send order.
- Remaining > 0 -> GAP; remaining = 0 -> IDLE.
REQ-016 GAP SHALL last exactly INTER_BYTE_DELAY cycles, then go to START.
REQ-017 With MSB_FIRST = 1 and count k < NB, the bytes sent SHALL be byte[NB-1] down to byte[NB-k].
- With MSB_FIRST = 0, the bytes sent SHALL be byte[0] up to byte[k-1].
REQ-018 tx_start SHALL never assert outside START.
- tx_busy levels outside WAIT_BUSY and WAIT_DONE SHALL be ignored.
REQ-019 disp_data and disp_en SHALL hold between LOAD events; a disp_req = 0 entry clears disp_en but leaves disp_data.
REQ-020 idle SHALL be combinational: (state == IDLE) and queue empty.

Reset
REQ-021 reset low SHALL immediately force:
- state IDLE; queue empty.
- tx_start, tx_data, disp_data, disp_en, fifo_full, overflow = 0; idle = 1.
REQ-022 Reset mid-transfer SHALL abort the transfer and discard queued entries.
- After reset release, no further tx_start SHALL occur until a new op_done.

Verification
REQ-023 Single result: RESULT_W=32, MSB_FIRST=0, LOAD_DELAY=4, INTER_BYTE_DELAY=10, result 0x11223344, count 4, UART model busy for 20 cycles.
- Required: tx_data 0x44, 0x33, 0x22, 0x11; 4 tx_start pulses.
- First pulse 6 cycles after the op_done edge (1 IDLE, 1 LOAD, 4 WAIT_LOAD).
- Exactly 10 cycles between tx_busy fall and the next tx_start.
REQ-024 MSB_FIRST=1, count 2, result 0xA1B2C3D4 -> bytes 0xA1, 0xB2 only.
- Count 0 and count 7 -> 4 bytes each.
REQ-025 FIFO_DEPTH=4: five op_done pulses during the first transfer.
- Required: fifo_full = 1 after the queue fills; 5th pulse dropped; overflow = 1.
- Transmission continues in order 1..4.
- Push coinciding with LOAD while full is accepted.
REQ-026 Display: entry A (disp_req=1, 0x00000123), then entry B (disp_req=0, 0xFFFF0000).
- After A's LOAD: disp_en = 1, disp_data = 0x123.
- After B's LOAD: disp_en = 0, disp_data = 0x123.
REQ-027 Reset asserted during GAP of byte 2 with 2 entries queued.
- Required: all outputs at reset values within the reset cycle; idle = 1 after release; no tx_start for 1000 cycles.
REQ-028 tx_busy stuck at 0 after START -> FSM holds in WAIT_BUSY; no second tx_start; idle = 0.
